// File: rtl/tcdm_demux_pkg.sv
// Shared types and defaults for the TCDM address-decoded demultiplexers.
package tcdm_demux_pkg;

  localparam int unsigned DEF_NB_MASTER       = 3;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned DEF_ADDR_WIDTH      = 32;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hBADACCE5;

  // Target index; the value DEF_NB_MASTER encodes the error target.
  typedef logic [$clog2(DEF_NB_MASTER+1)-1:0]       sel_t;
  typedef logic [$clog2(DEF_MAX_OUTSTANDING+1)-1:0] cnt_t;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] start_addr;
    logic [DEF_ADDR_WIDTH-1:0] end_addr;
  } addr_rule_t;

endpackage

// File: rtl/tcdm_addr_decode.sv
// Combinational address-window matcher: the lowest-index window containing
// addr wins; no match yields sel = NB_RULES.
module tcdm_addr_decode #(
  parameter int unsigned NB_RULES   = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEL_W      = $clog2(NB_RULES+1)
) (
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [NB_RULES*ADDR_WIDTH-1:0] rule_start,
  input  logic [NB_RULES*ADDR_WIDTH-1:0] rule_end,
  output logic [SEL_W-1:0]               sel,
  output logic                           match
);

  // Scanning from the top down lets the lowest matching index overwrite last.
  // A window with end <= start can never satisfy both bounds.
  always_comb begin
    sel   = SEL_W'(NB_RULES);
    match = 1'b0;
    for (int i = NB_RULES-1; i >= 0; i--) begin
      if ((addr >= rule_start[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (addr <  rule_end[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        sel   = SEL_W'(i);
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcdm_addr_demux.sv
// 1-to-NB_MASTER TCDM demux with programmable windows, in-order response
// tracking and an internal error responder for unmapped addresses.
module tcdm_addr_demux
  import tcdm_demux_pkg::*;
#(
  parameter int unsigned     NB_MASTER       = 3,
  parameter int unsigned     ADDR_WIDTH      = 32,
  parameter int unsigned     DATA_WIDTH      = 32,
  parameter int unsigned     MAX_OUTSTANDING = 4,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_RDATA_DEF)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NB_MASTER*ADDR_WIDTH-1:0] rule_start_i,
  input  logic [NB_MASTER*ADDR_WIDTH-1:0] rule_end_i,
  input  logic                            s_req_i,
  input  logic [ADDR_WIDTH-1:0]           s_add_i,
  input  logic                            s_wen_i,
  input  logic [DATA_WIDTH-1:0]           s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]         s_be_i,
  output logic                            s_gnt_o,
  output logic                            s_r_valid_o,
  output logic [DATA_WIDTH-1:0]           s_r_rdata_o,
  output logic                            s_r_opc_o,
  output logic [NB_MASTER-1:0]            m_req_o,
  output logic [ADDR_WIDTH-1:0]           m_add_o,
  output logic                            m_wen_o,
  output logic [DATA_WIDTH-1:0]           m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]         m_be_o,
  input  logic [NB_MASTER-1:0]            m_gnt_i,
  input  logic [NB_MASTER-1:0]            m_r_valid_i,
  input  logic [NB_MASTER*DATA_WIDTH-1:0] m_r_rdata_i,
  output logic                            busy_o,
  output logic                            spurious_o
);

  localparam int unsigned      SEL_W   = $clog2(NB_MASTER+1);
  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  // Handshake: a request transfers in the cycle where req and gnt are both
  // high; every granted request gets exactly one r_valid pulse, in order,
  // one or more cycles later. r_valid has no back-pressure.

  logic [SEL_W-1:0]      dec_sel;
  logic                  dec_match;
  logic [SEL_W-1:0]      act_sel_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_pend_q;
  logic                  spurious_q;

  logic                  issue_ok;
  logic                  resp;
  logic                  act_rvalid;
  logic [DATA_WIDTH-1:0] act_rdata;
  logic [NB_MASTER-1:0]  act_mask;

  tcdm_addr_decode #(
    .NB_RULES   (NB_MASTER),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_W      (SEL_W)
  ) u_decode (
    .addr       (s_add_i),
    .rule_start (rule_start_i),
    .rule_end   (rule_end_i),
    .sel        (dec_sel),
    .match      (dec_match)
  );

  assign m_add_o   = s_add_i;
  assign m_wen_o   = s_wen_i;
  assign m_wdata_o = s_wdata_i;
  assign m_be_o    = s_be_i;

  // A target switch waits for the count to drain so responses stay ordered.
  always_comb begin
    issue_ok = s_req_i & ~rst_i & (cnt_q < CNT_MAX) &
               ((cnt_q == '0) | (dec_sel == act_sel_q));
    m_req_o  = '0;
    s_gnt_o  = 1'b0;
    if (issue_ok) begin
      if (!dec_match) begin
        s_gnt_o = 1'b1;
      end else begin
        for (int i = 0; i < NB_MASTER; i++) begin
          if (dec_sel == SEL_W'(i)) begin
            m_req_o[i] = 1'b1;
            s_gnt_o    = m_gnt_i[i];
          end
        end
      end
    end
  end

  always_comb begin
    act_rvalid = 1'b0;
    act_rdata  = '0;
    act_mask   = '0;
    for (int i = 0; i < NB_MASTER; i++) begin
      if (act_sel_q == SEL_W'(i)) begin
        act_rvalid  = m_r_valid_i[i];
        act_rdata   = m_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        act_mask[i] = (cnt_q != '0);
      end
    end
  end

  // err_pend_q can only be set while act_sel_q points at the error target.
  assign resp        = (act_rvalid & (cnt_q != '0)) | err_pend_q;
  assign s_r_valid_o = ~rst_i & resp;
  assign s_r_opc_o   = ~rst_i & err_pend_q;
  assign s_r_rdata_o = rst_i      ? '0        :
                       err_pend_q ? ERR_RDATA : act_rdata;
  assign busy_o      = ~rst_i & (cnt_q != '0);
  assign spurious_o  = spurious_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      act_sel_q  <= '0;
      err_pend_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      err_pend_q <= s_gnt_o & ~dec_match;
      if (s_gnt_o) act_sel_q <= dec_sel;
      case ({s_gnt_o, resp})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (|(m_r_valid_i & ~act_mask)) spurious_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcdm_addr_demux.sv
// Directed bench for tcdm_addr_demux with a response scoreboard.
module tb_tcdm_addr_demux;
  import tcdm_demux_pkg::*;

  localparam int NB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW/8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB*AW-1:0] rule_start;
  logic [NB*AW-1:0] rule_end;
  logic            s_req;
  logic [AW-1:0]   s_add;
  logic            s_wen;
  logic [DW-1:0]   s_wdata;
  logic [BW-1:0]   s_be;
  logic            s_gnt;
  logic            s_r_valid;
  logic [DW-1:0]   s_r_rdata;
  logic            s_r_opc;
  logic [NB-1:0]   m_req;
  logic [AW-1:0]   m_add;
  logic            m_wen;
  logic [DW-1:0]   m_wdata;
  logic [BW-1:0]   m_be;
  logic [NB-1:0]   m_gnt;
  logic [NB-1:0]   m_r_valid;
  logic [NB*DW-1:0] m_r_rdata;
  logic            busy;
  logic            spurious;

  int checks   = 0;
  int failures = 0;

  logic [DW:0] exp_q[$];   // {opc, rdata}
  logic [DW:0] mon_exp;
  addr_rule_t  rules [NB];

  tcdm_addr_demux dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rule_start_i (rule_start),
    .rule_end_i   (rule_end),
    .s_req_i      (s_req),
    .s_add_i      (s_add),
    .s_wen_i      (s_wen),
    .s_wdata_i    (s_wdata),
    .s_be_i       (s_be),
    .s_gnt_o      (s_gnt),
    .s_r_valid_o  (s_r_valid),
    .s_r_rdata_o  (s_r_rdata),
    .s_r_opc_o    (s_r_opc),
    .m_req_o      (m_req),
    .m_add_o      (m_add),
    .m_wen_o      (m_wen),
    .m_wdata_o    (m_wdata),
    .m_be_o       (m_be),
    .m_gnt_i      (m_gnt),
    .m_r_valid_i  (m_r_valid),
    .m_r_rdata_i  (m_r_rdata),
    .busy_o       (busy),
    .spurious_o   (spurious)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  // Checker and driver tasks
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic req(input logic [AW-1:0] a);
    s_req   = 1'b1;
    s_add   = a;
    s_wen   = 1'b1;
    s_wdata = $urandom_range(0, 255);
    s_be    = 4'hF;
  endtask

  task automatic respond(input int p, input logic [DW-1:0] d);
    m_r_valid    = '0;
    m_r_valid[p] = 1'b1;
    m_r_rdata[p*DW +: DW] = d;
    exp_q.push_back({1'b0, d});
  endtask

  task automatic no_resp;
    m_r_valid = '0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (s_r_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: got opc=%0b rdata=0x%0h required no response", s_r_opc, s_r_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("resp_opc_rdata", {31'd0, s_r_opc, s_r_rdata}, {31'd0, mon_exp});
      end
    end
  end

  initial begin
    rules[0] = '{start_addr: 32'h1C00_0000, end_addr: 32'h1C08_0000};
    rules[1] = '{start_addr: 32'h1C01_0000, end_addr: 32'h1C01_4000};
    rules[2] = '{start_addr: 32'h1A10_0000, end_addr: 32'h1A20_0000};
    for (int i = 0; i < NB; i++) begin
      rule_start[i*AW +: AW] = rules[i].start_addr;
      rule_end[i*AW +: AW]   = rules[i].end_addr;
    end
    rst = 1'b1; s_req = 1'b0; s_add = '0; s_wen = 1'b1; s_wdata = '0; s_be = '0;
    m_gnt = '0; m_r_valid = '0; m_r_rdata = '0;
    tick; tick;

    // Reset holds off requests even with a mapped request and grants offered
    req(32'h1C01_0004); m_gnt = 3'b111;
    sample;
    chk("reset_m_req", 64'(m_req), 64'd0);
    chk("reset_gnt", 64'(s_gnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rvalid", 64'(s_r_valid), 64'd0);
    tick;
    rst = 1'b0; s_req = 1'b0; m_gnt = '0;
    sample;
    chk("reset_spurious", 64'(spurious), 64'd0);

    // Overlapping windows: P0 wins over P1
    tick;
    req(32'h1C01_0004); m_gnt = 3'b001;
    sample;
    chk("t1_m_req", 64'(m_req), 64'b001);
    chk("t1_gnt", 64'(s_gnt), 64'd1);
    chk("t1_m_add", 64'(m_add), 64'h1C01_0004);
    tick;
    s_req = 1'b0; respond(0, 32'h1234_5678);
    sample;
    chk("t1_busy", 64'(busy), 64'd1);
    tick;
    no_resp;
    sample;
    chk("t1_cnt", 64'(dut.cnt_q), 64'd0);

    // Unmapped address: same-cycle grant, error response next cycle
    tick;
    req(32'h0000_0010); m_gnt = '0;
    sample;
    chk("t2_gnt", 64'(s_gnt), 64'd1);
    chk("t2_m_req", 64'(m_req), 64'd0);
    exp_q.push_back({1'b1, 32'hBADA_CCE5});
    tick;
    s_req = 1'b0;
    sample;
    chk("t2_resp_m_req", 64'(m_req), 64'd0);
    tick;
    for (int k = 0; k < 3; k++) begin
      req(32'h0000_0020 + 32'(k*4));
      sample;
      chk("t2_b2b_gnt", 64'(s_gnt), 64'd1);
      exp_q.push_back({1'b1, 32'hBADA_CCE5});
      tick;
    end
    s_req = 1'b0;
    sample;
    tick;
    sample;
    chk("t2_busy", 64'(busy), 64'd0);

    // Fill to MAX_OUTSTANDING on P2; freed slot usable only next cycle
    tick;
    m_gnt = 3'b100;
    for (int k = 0; k < 4; k++) begin
      req(32'h1A10_0000 + 32'(k*4));
      sample;
      chk("t3_fill_gnt", 64'(s_gnt), 64'd1);
      tick;
    end
    req(32'h1A10_0010);
    sample;
    chk("t3_full_gnt", 64'(s_gnt), 64'd0);
    chk("t3_full_m_req", 64'(m_req), 64'd0);
    chk("t3_full_cnt", 64'(dut.cnt_q), 64'd4);
    tick;
    respond(2, 32'hA000_0000);
    sample;
    chk("t3_nobypass_gnt", 64'(s_gnt), 64'd0);
    tick;
    no_resp;
    sample;
    chk("t3_next_gnt", 64'(s_gnt), 64'd1);
    chk("t3_next_m_req", 64'(m_req), 64'b100);
    tick;
    s_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      respond(2, 32'hA000_0000 + 32'(k));
      tick;
    end
    no_resp;
    sample;
    chk("t3_busy", 64'(busy), 64'd0);

    // Target switch stalls until P2 drains
    tick;
    m_gnt = 3'b101;
    req(32'h1A10_0100);
    sample;
    chk("t4_p2_gnt", 64'(s_gnt), 64'd1);
    tick;
    req(32'h1A10_0104);
    tick;
    req(32'h1C00_0100); respond(2, 32'h0000_00B1);
    sample;
    chk("t4_stall_m_req", 64'(m_req), 64'd0);
    chk("t4_stall_gnt", 64'(s_gnt), 64'd0);
    tick;
    respond(2, 32'h0000_00B2);
    sample;
    chk("t4_stall2_m_req", 64'(m_req), 64'd0);
    tick;
    no_resp;
    sample;
    chk("t4_issue_m_req", 64'(m_req), 64'b001);
    chk("t4_issue_gnt", 64'(s_gnt), 64'd1);
    tick;
    s_req = 1'b0; respond(0, 32'h0000_00C0);
    tick;
    no_resp;
    sample;
    chk("t4_busy", 64'(busy), 64'd0);

    // Continuous stream: grant and response every cycle keeps cnt at 1
    tick;
    m_gnt = 3'b100;
    req(32'h1A10_0200);
    tick;
    for (int k = 0; k < 5; k++) begin
      req(32'h1A10_0204 + 32'(k*4));
      respond(2, 32'h0000_00D0 + 32'(k));
      sample;
      chk("t5_cnt", 64'(dut.cnt_q), 64'd1);
      chk("t5_busy", 64'(busy), 64'd1);
      chk("t5_gnt", 64'(s_gnt), 64'd1);
      tick;
    end
    s_req = 1'b0; respond(2, 32'h0000_00D5);
    tick;
    no_resp;
    sample;
    chk("t5_busy_end", 64'(busy), 64'd0);
    chk("t5_spurious", 64'(spurious), 64'd0);

    // Reset mid-transaction, then a late response is spurious
    tick;
    req(32'h1A10_0300);
    tick;
    req(32'h1A10_0304);
    tick;
    s_req = 1'b0;
    sample;
    chk("t6_cnt_pre", 64'(dut.cnt_q), 64'd2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    sample;
    chk("t6_cnt", 64'(dut.cnt_q), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    tick;
    m_r_valid = 3'b100; m_r_rdata[2*DW +: DW] = 32'h0000_00E0;
    sample;
    chk("t6_late_rvalid", 64'(s_r_valid), 64'd0);
    tick;
    no_resp;
    sample;
    chk("t6_spurious", 64'(spurious), 64'd1);

    tick;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
